// File: rtl/lcd_result_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_result_writer                                            |
// | Description : Shows an 8-bit result as two hex digits on an HD44780        |
// |               character LCD (8-bit, write-only). Runs the power-up init,   |
// |               then rewrites line 1 cols 0-1 on value change or Refresh.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcd_result_writer #(
   parameter int POWERUP_CYC = 750000,
   parameter int SETUP_CYC   = 4,
   parameter int EN_CYC      = 12,
   parameter int CMD_CYC     = 2000,
   parameter int CLR_CYC     = 80000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] Result_LCD,
   input  logic       Refresh,
   output logic [7:0] LCD_DB,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       Busy,
   output logic       Ready
);

   // One counter serves every delay, so it is sized for the longest one.
   localparam int MAX_A   = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
   localparam int MAX_B   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
   localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYC - 1);

   localparam logic [2:0] INIT_LAST_IDX = 3'd5;
   localparam logic [2:0] REF_LAST_IDX  = 3'd2;

   // SETUP/EN_HIGH/HOLD form the byte-write phases, shared by init and refresh.
   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      IDLE     = 3'd1,
      SETUP    = 3'd2,
      EN_HIGH  = 3'd3,
      HOLD     = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic             in_init, init_nxt;
   logic [7:0]       db, db_nxt;
   logic             rs, rs_nxt;
   logic [7:0]       shown, shown_nxt;
   logic             shown_valid, valid_nxt;
   logic             ready, ready_nxt;
   logic [CNT_W-1:0] hold_last;
   logic [8:0]       next_byte;
   logic [2:0]       last_idx;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Returns {RS, DB} for byte i of the init or refresh sequence.
   function automatic logic [8:0] seq_byte(input logic init_mode, input logic [2:0] i,
                                           input logic [7:0] val);
      logic [8:0] b;
      b = 9'h000;
      if (init_mode) begin
         case (i)
            3'd0, 3'd1, 3'd2: b = 9'h038;
            3'd3:             b = 9'h00C;
            3'd4:             b = 9'h001;
            default:          b = 9'h006;
         endcase
      end else begin
         case (i)
            3'd0:    b = 9'h080;
            3'd1:    b = {1'b1, hex_char(val[7:4])};
            default: b = {1'b1, hex_char(val[3:0])};
         endcase
      end
      return b;
   endfunction

   // State register and datapath registers; reset drops EN immediately via state.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state       <= PWR_WAIT;
         cnt         <= '0;
         idx         <= 3'd0;
         in_init     <= 1'b1;
         db          <= 8'h00;
         rs          <= 1'b0;
         shown       <= 8'h00;
         shown_valid <= 1'b0;
         ready       <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         in_init     <= init_nxt;
         db          <= db_nxt;
         rs          <= rs_nxt;
         shown       <= shown_nxt;
         shown_valid <= valid_nxt;
         ready       <= ready_nxt;
      end
   end

   // Next-state logic: sequencing, delay counting and the single sample point in IDLE.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      idx_nxt   = idx;
      init_nxt  = in_init;
      db_nxt    = db;
      rs_nxt    = rs;
      shown_nxt = shown;
      valid_nxt = shown_valid;
      ready_nxt = ready;
      hold_last = (db == 8'h01 && !rs) ? CLR_LAST : CMD_LAST;
      next_byte = seq_byte(in_init, idx + 3'd1, shown);
      last_idx  = in_init ? INIT_LAST_IDX : REF_LAST_IDX;
      case (state)
         PWR_WAIT: begin
            if (cnt == PWR_LAST) begin
               state_nxt         = SETUP;
               cnt_nxt           = '0;
               idx_nxt           = 3'd0;
               init_nxt          = 1'b1;
               {rs_nxt, db_nxt}  = 9'h038;
            end
         end
         IDLE: begin
            cnt_nxt = '0;
            if (!shown_valid || (Result_LCD != shown) || Refresh) begin
               state_nxt        = SETUP;
               idx_nxt          = 3'd0;
               init_nxt         = 1'b0;
               shown_nxt        = Result_LCD;
               valid_nxt        = 1'b1;
               {rs_nxt, db_nxt} = 9'h080;
            end
         end
         SETUP: begin
            if (cnt == SETUP_LAST) begin
               state_nxt = EN_HIGH;
               cnt_nxt   = '0;
            end
         end
         EN_HIGH: begin
            if (cnt == EN_LAST) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end
         end
         HOLD: begin
            if (cnt == hold_last) begin
               cnt_nxt = '0;
               if (idx == last_idx) begin
                  state_nxt = IDLE;
                  if (in_init) begin
                     ready_nxt = 1'b1;
                     valid_nxt = 1'b0;
                  end
               end else begin
                  state_nxt        = SETUP;
                  idx_nxt          = idx + 3'd1;
                  {rs_nxt, db_nxt} = next_byte;
               end
            end
         end
         default: state_nxt = PWR_WAIT;
      endcase
   end

   assign LCD_DB = db;
   assign LCD_RS = rs;
   assign LCD_RW = 1'b0;
   assign LCD_EN = (state == EN_HIGH);
   assign Busy   = (state != IDLE);
   assign Ready  = ready;

endmodule
`default_nettype wire

// File: tb/tb_lcd_result_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lcd_result_writer                                         |
// | Description : Self-checking bench for lcd_result_writer: directed and      |
// |               randomized display updates against a byte-log model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lcd_result_writer;

   localparam int P_PWR   = 20;
   localparam int P_SETUP = 1;
   localparam int P_EN    = 2;
   localparam int P_CMD   = 4;
   localparam int P_CLR   = 10;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [7:0] Result_LCD = 8'h00;
   logic       Refresh = 1'b0;
   logic [7:0] LCD_DB;
   logic       LCD_RS;
   logic       LCD_RW;
   logic       LCD_EN;
   logic       Busy;
   logic       Ready;

   int n_cmp = 0;
   int n_bad = 0;

   // Observed and expected traffic.
   logic [8:0]  log_q[$];
   int unsigned rise_q[$];
   logic [8:0]  exp_val[$];
   int          exp_last[$];
   logic [7:0]  model_shown = 8'h00;

   lcd_result_writer #(
      .POWERUP_CYC (P_PWR),
      .SETUP_CYC   (P_SETUP),
      .EN_CYC      (P_EN),
      .CMD_CYC     (P_CMD),
      .CLR_CYC     (P_CLR)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Result_LCD (Result_LCD),
      .Refresh    (Refresh),
      .LCD_DB     (LCD_DB),
      .LCD_RS     (LCD_RS),
      .LCD_RW     (LCD_RW),
      .LCD_EN     (LCD_EN),
      .Busy       (Busy),
      .Ready      (Ready)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic int wcyc(input logic [8:0] b);
      return (b == 9'h001) ? P_CLR : P_CMD;
   endfunction

   task automatic push_exp(input logic [8:0] b, input int last);
      exp_val.push_back(b);
      exp_last.push_back(last);
   endtask

   task automatic add_init();
      push_exp(9'h038, 0);
      push_exp(9'h038, 0);
      push_exp(9'h038, 0);
      push_exp(9'h00C, 0);
      push_exp(9'h001, 0);
      push_exp(9'h006, 1);
   endtask

   task automatic add_refresh(input logic [7:0] v);
      push_exp(9'h080, 0);
      push_exp({1'b1, hexc(v[7:4])}, 0);
      push_exp({1'b1, hexc(v[3:0])}, 1);
      model_shown = v;
   endtask

   task automatic clear_all();
      log_q.delete();
      rise_q.delete();
      exp_val.delete();
      exp_last.delete();
   endtask

   // Waits for three consecutive idle samples, bounded by a cycle budget.
   task automatic settle(input string tag, input int budget);
      int quiet;
      int n;
      quiet = 0;
      n = 0;
      while (quiet < 3 && n < budget) begin
         @(negedge Clock);
         n++;
         if (!Busy) quiet++;
         else quiet = 0;
      end
      chk({tag, "_settle"}, quiet >= 3, 1);
   endtask

   // Byte log and the spacing of EN rises against the model.
   task automatic compare_log(input string tag);
      chk({tag, "_count"}, log_q.size(), exp_val.size());
      for (int i = 0; i < log_q.size() && i < exp_val.size(); i++)
         chk({tag, "_byte"}, log_q[i], exp_val[i]);
      for (int i = 0; i + 1 < rise_q.size() && i + 1 < exp_val.size(); i++)
         chk({tag, "_gap"}, rise_q[i+1] - rise_q[i],
             P_SETUP + P_EN + wcyc(exp_val[i]) + exp_last[i]);
      clear_all();
   endtask

   // Log {RS,DB} where the LCD latches it.
   always @(negedge LCD_EN) begin
      if (Reset) log_q.push_back({LCD_RS, LCD_DB});
   end

   // Per-cycle timing monitor: EN width, setup and hold stability.
   logic       mon_prev_en = 1'b0;
   logic [8:0] mon_prev_bus = 9'h000;
   logic [8:0] mon_pulse_bus = 9'h000;
   int         mon_run = 0;
   int         mon_hold = 0;
   int         cyc = 0;
   always @(negedge Clock) begin
      logic [8:0] bus;
      cyc++;
      bus = {LCD_RS, LCD_DB};
      if (!Reset) begin
         mon_prev_en = 1'b0;
         mon_run = 0;
         mon_hold = 0;
      end else begin
         if (LCD_EN) begin
            if (!mon_prev_en) begin
               rise_q.push_back(cyc);
               mon_pulse_bus = bus;
               chk("setup_stable", bus, mon_prev_bus);
               chk("rw_low", LCD_RW, 0);
               mon_run = 0;
            end else begin
               chk("en_stable", bus, mon_pulse_bus);
            end
            mon_run++;
         end else if (mon_prev_en) begin
            chk("en_width", mon_run, P_EN);
            chk("hold_stable", bus, mon_pulse_bus);
            mon_hold = wcyc(mon_pulse_bus) - 1;
         end else if (mon_hold > 0) begin
            chk("hold_stable", bus, mon_pulse_bus);
            mon_hold--;
         end
         mon_prev_en = LCD_EN;
         mon_prev_bus = bus;
      end
   end

   initial begin
      int kind;
      int k;
      int found;
      logic [7:0] v;
      logic [7:0] w;

      // Reset values
      repeat (3) @(negedge Clock);
      chk("reset_outputs", {LCD_DB, LCD_RS, LCD_RW, LCD_EN, Busy, Ready},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

      // Power-up, init and forced first refresh of 0x00
      Reset = 1'b1;
      clear_all();
      for (int i = 0; i < P_PWR; i++) begin
         @(negedge Clock);
         chk("pwr_no_en", LCD_EN, 0);
      end
      chk("ready_during_init", Ready, 0);
      add_init();
      add_refresh(8'h00);
      settle("init", 500);
      compare_log("init");
      chk("ready_after_init", Ready, 1);
      chk("busy_after_init", Busy, 0);

      // Single value change
      Result_LCD = 8'h3A;
      add_refresh(8'h3A);
      @(negedge Clock);
      chk("busy_on_change", Busy, 1);
      settle("val3a", 200);
      compare_log("val3a");

      // Change during refresh: both values shown, in order
      Result_LCD = 8'h12;
      add_refresh(8'h12);
      repeat (2) @(negedge Clock);
      Result_LCD = 8'hFF;
      add_refresh(8'hFF);
      settle("midchg", 300);
      compare_log("midchg");

      // Long quiet period, then one Refresh pulse
      repeat (1000) @(negedge Clock);
      chk("quiet_no_en", rise_q.size(), 0);
      Refresh = 1'b1;
      @(negedge Clock);
      Refresh = 1'b0;
      add_refresh(model_shown);
      settle("pulse", 200);
      compare_log("pulse");

      // Randomized updates
      for (int it = 0; it < 16; it++) begin
         kind = $urandom_range(0, 3);
         v = 8'($urandom_range(0, 255));
         case (kind)
            0: begin
               Result_LCD = v;
               if (v != model_shown) add_refresh(v);
               @(negedge Clock);
            end
            1: begin
               Result_LCD = v;
               Refresh = 1'b1;
               add_refresh(v);
               @(negedge Clock);
               Refresh = 1'b0;
            end
            2: begin
               Refresh = 1'b1;
               add_refresh(model_shown);
               @(negedge Clock);
               Refresh = 1'b0;
            end
            default: begin
               v = model_shown ^ 8'($urandom_range(1, 255));
               Result_LCD = v;
               add_refresh(v);
               k = $urandom_range(1, 8);
               repeat (k) @(negedge Clock);
               w = 8'($urandom_range(0, 255));
               Result_LCD = w;
               @(negedge Clock);
               Refresh = 1'b1;
               @(negedge Clock);
               Refresh = 1'b0;
               if (w != v) add_refresh(w);
            end
         endcase
         settle("rand", 300);
         compare_log("rand");
      end

      // Reset in the middle of an init EN pulse
      Reset = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      clear_all();
      found = 0;
      for (int n = 0; n < 200 && found == 0; n++) begin
         @(negedge Clock);
         if (LCD_EN && n >= 40) found = 1;
      end
      chk("en_found", found, 1);
      Reset = 1'b0;
      #1;
      chk("reset_mid_en", {LCD_DB, LCD_RS, LCD_RW, LCD_EN, Busy, Ready},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      clear_all();
      for (int i = 0; i < P_PWR; i++) begin
         @(negedge Clock);
         chk("repwr_no_en", LCD_EN, 0);
      end
      add_init();
      add_refresh(Result_LCD);
      settle("reinit", 500);
      compare_log("reinit");
      chk("ready_after_reinit", Ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
